piso_serializer: RTL and testbench

Parallel-in, serial-out shift register: captures an NBITS-wide word on a valid/ready load handshake and shifts it out one bit per enabled clock on a single serial line, with a per-bit valid and an end-of-frame pulse. It is the transmit-side counterpart of the serial-in/parallel-out register in the lab top level. It is instantiated in `top` with `paralelo_in` driven from SWI[7:4], the control inputs driven from other SWI bits, and `serial_out`, `serial_valid` and `done` shown on LED.

---
 rtl/piso_serializer_if.sv | 38 +++
 rtl/piso_serializer.sv | 95 +++++++++
 tb/tb_piso_serializer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle for piso_serializer.
// The master side is the word source; the slave side is the serializer.
interface piso_serializer_if #(
    parameter int NBITS = 4
);
    localparam int CW = $clog2(NBITS);

    logic             load_valid;
    logic             load_ready;
    logic [NBITS-1:0] paralelo_in;
    logic             shift_en;
    logic             serial_out;
    logic             serial_valid;
    logic [CW-1:0]    bit_count;
    logic             done;

    modport master (
        output load_valid,
        output paralelo_in,
        output shift_en,
        input  load_ready,
        input  serial_out,
        input  serial_valid,
        input  bit_count,
        input  done
    );

    modport slave (
        input  load_valid,
        input  paralelo_in,
        input  shift_en,
        output load_ready,
        output serial_out,
        output serial_valid,
        output bit_count,
        output done
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter: loads a word on a valid/ready handshake,
// sends one bit per enabled clock, then pulses done for one cycle.
module piso_serializer #(
    parameter int NBITS     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic            clk_2,
    input  logic            reset,
    piso_serializer_if.slave bus
);
    localparam int CW = $clog2(NBITS);
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [NBITS-1:0] sreg_q, sreg_d;
    logic             serial_q, serial_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sreg_q   <= '0;
            serial_q <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            serial_q <= serial_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        serial_d = serial_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.load_valid) begin
                    state_d  = SHIFT;
                    sreg_d   = bus.paralelo_in;
                    serial_d = MSB_FIRST ? bus.paralelo_in[NBITS-1]
                                         : bus.paralelo_in[0];
                    valid_d  = 1'b1;
                    cnt_d    = '0;
                end
            end
            SHIFT: begin
                if (bus.shift_en) begin
                    if (cnt_q == LAST) begin
                        state_d  = DONE;
                        sreg_d   = '0;
                        serial_d = 1'b0;
                        valid_d  = 1'b0;
                        cnt_d    = '0;
                        done_d   = 1'b1;
                    end else begin
                        // serial_q already holds the output-end bit, so the
                        // next bit is the one right behind it
                        sreg_d   = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
                        serial_d = MSB_FIRST ? sreg_q[NBITS-2] : sreg_q[1];
                        cnt_d    = cnt_q + CW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.load_ready   = (state_q == IDLE);
    assign bus.serial_out   = serial_q;
    assign bus.serial_valid = valid_q;
    assign bus.bit_count    = cnt_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: drives an LSB-first and an MSB-first serializer with the
// same stimulus and checks every consumed bit, done pulse and frame timing.
module tb_piso_serializer;
    localparam int NB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic       shift_en;
    logic [3:0] paralelo_in;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    bit armed = 1'b0;

    int q0[$];
    int q1[$];
    int pend0 = 0;
    int pend1 = 0;
    int last0 = -1;
    int last1 = -1;
    int dones0 = 0;

    int prev_acc = 0;
    bit prev_b2b = 1'b0;
    int prev_st = 0;

    piso_serializer_if #(.NBITS(NB)) if0 ();
    piso_serializer_if #(.NBITS(NB)) if1 ();

    assign if0.load_valid  = load_valid;
    assign if0.paralelo_in = paralelo_in;
    assign if0.shift_en    = shift_en;
    assign if1.load_valid  = load_valid;
    assign if1.paralelo_in = paralelo_in;
    assign if1.shift_en    = shift_en;

    piso_serializer #(.NBITS(NB), .MSB_FIRST(1'b0)) u_lsb (
        .clk_2(clk),
        .reset(reset),
        .bus  (if0.slave)
    );

    piso_serializer #(.NBITS(NB), .MSB_FIRST(1'b1)) u_msb (
        .clk_2(clk),
        .reset(reset),
        .bus  (if1.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_serial_out", int'(if0.serial_out), 0);
        chk("rst_serial_valid", int'(if0.serial_valid), 0);
        chk("rst_bit_count", int'(if0.bit_count), 0);
        chk("rst_done", int'(if0.done), 0);
        chk("rst_load_ready", int'(if0.load_ready), 1);
        chk("rst_msb_valid", int'(if1.serial_valid), 0);
        chk("rst_msb_ready", int'(if1.load_ready), 1);
    endtask

    // Monitor: on each consumed bit pop the expected {index, bit}.
    always @(negedge clk) begin
        int e;
        if (armed && !reset) begin
            if (if0.serial_valid && shift_en) begin
                if (q0.size() == 0) chk("lsb_extra_bit", 1, 0);
                else begin
                    e = q0.pop_front();
                    chk("lsb_bit", int'(if0.serial_out), e % 2);
                    chk("lsb_idx", int'(if0.bit_count), e / 2);
                    last0 = e / 2;
                end
            end
            if (if1.serial_valid && shift_en) begin
                if (q1.size() == 0) chk("msb_extra_bit", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("msb_bit", int'(if1.serial_out), e % 2);
                    chk("msb_idx", int'(if1.bit_count), e / 2);
                    last1 = e / 2;
                end
            end
            if (!if0.serial_valid)
                chk("lsb_idle_out", int'({if0.serial_out, if0.bit_count}), 0);
            if (if0.done) begin
                dones0++;
                chk("lsb_done_pending", int'(pend0 > 0), 1);
                chk("lsb_done_last", last0, NB - 1);
                if (pend0 > 0) pend0--;
                last0 = -1;
            end
            if (if1.done) begin
                chk("msb_done_pending", int'(pend1 > 0), 1);
                chk("msb_done_last", last1, NB - 1);
                if (pend1 > 0) pend1--;
                last1 = -1;
            end
        end
    end

    // One frame. stall_k/stall_n: hold shift_en low stall_n cycles once
    // bit stall_k is presented. busy: 1 = one directed busy load, 2 = random.
    // abort_k >= 0: assert reset while bit abort_k is on the line.
    task automatic frame(input logic [3:0] w, input bit b2b,
                         input int stall_k, input int stall_n,
                         input bit rnd, input int busy, input int abort_k);
        int t, c, st, cons;
        paralelo_in = w;
        load_valid  = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!if0.load_ready && t < 50);
        if (!if0.load_ready) begin
            chk("accept_timeout", 0, 1);
            load_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (prev_b2b) chk("b2b_period", cyc - prev_acc, NB + 2 + prev_st);
        prev_acc = cyc;
        prev_b2b = b2b;
        for (int k = 0; k < NB; k++) begin
            q0.push_back(k * 2 + int'((w >> k) & 4'd1));
            q1.push_back(k * 2 + int'((w >> (NB - 1 - k)) & 4'd1));
        end
        pend0++;
        pend1++;
        #1;
        if (!b2b) load_valid = 1'b0;
        c = 0;
        st = 0;
        cons = 0;
        while (1) begin
            c++;
            if (rnd) shift_en = ($urandom_range(0, 3) != 0);
            else shift_en = !(cons == stall_k && st < stall_n);
            if (cons < NB && ((busy == 1 && c == 2) ||
                              (busy == 2 && $urandom_range(0, 3) == 0))) begin
                load_valid  = 1'b1;
                paralelo_in = (busy == 1) ? 4'hF : 4'($urandom);
            end
            @(negedge clk);
            if (abort_k >= 0 && if0.serial_valid && int'(if0.bit_count) == abort_k) begin
                #1 reset = 1'b1;
                #1 chk_reset_outputs();
                q0.delete();
                q1.delete();
                pend0 = 0;
                pend1 = 0;
                last0 = -1;
                last1 = -1;
                prev_b2b = 1'b0;
                load_valid = 1'b0;
                @(posedge clk);
                #1 reset = 1'b0;
                return;
            end
            if (if0.done) begin
                chk("done_cycle", c, NB + 1 + st);
                chk("done_sync", int'(if1.done), 1);
                prev_st = st;
                break;
            end
            if (c > 100) begin
                chk("done_timeout", 0, 1);
                break;
            end
            if (cons < NB) begin
                if (shift_en) cons++;
                else st++;
            end
            @(posedge clk);
            #1;
            if (!b2b) load_valid = 1'b0;
        end
    endtask

    initial begin
        int d0;
        reset = 1'b0;
        load_valid = 1'b0;
        shift_en = 1'b0;
        paralelo_in = 4'h0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1 chk_reset_outputs();
        armed = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        frame(4'b1011, 1'b0, -1, 0, 1'b0, 0, -1);
        @(posedge clk);
        #1 chk("ready_after_done", int'(if0.load_ready), 1);

        frame(4'b0110, 1'b0, 1, 3, 1'b0, 0, -1);
        frame(4'b0001, 1'b0, -1, 0, 1'b0, 1, -1);

        frame(4'b1010, 1'b0, -1, 0, 1'b0, 0, 2);
        d0 = dones0;
        repeat (6) @(posedge clk);
        #1 chk("no_done_after_abort", dones0 - d0, 0);
        frame(4'b0011, 1'b0, -1, 0, 1'b0, 0, -1);

        frame(4'b1100, 1'b1, -1, 0, 1'b0, 0, -1);
        frame(4'b0101, 1'b1, -1, 0, 1'b0, 0, -1);
        frame(4'b1001, 1'b0, -1, 0, 1'b0, 0, -1);

        for (int i = 0; i < 12; i++)
            frame(4'($urandom), (i != 11) && ($urandom_range(0, 1) == 1),
                  -1, 0, 1'b1, 2, -1);

        load_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("lsb_queue_empty", q0.size(), 0);
        chk("msb_queue_empty", q1.size(), 0);
        chk("frames_done", pend0 + pend1, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
